operand_fetch_stage: RTL and testbench
======================================

// Module: operand_fetch_stage
// PURPOSE
//  Decode-side operand fetch for the filter processor pipeline. Holds the 16x32 register file and a
//  pending-write scoreboard, reads source operands, and stalls on RAW hazards. Drives the
//  decode/execute pipeline register directly downstream: rs_a/rs_b, rd, ctrl, imm, and operand data.
//  Writeback from the last stage returns through the wb_* port.
// PARAMETERS
//  DATA_W  32  operand/immediate width
//  ADDR_W  4   register address width; NREGS = 2**ADDR_W
//  CTRL_W  4   opaque control field carried through unchanged
// PORTS
//  clk        in   1       clock, rising edge
//  rst        in   1       asynchronous, active-high reset
//  in_valid   in   1       upstream instruction valid
//  in_ready   out  1       stage can accept (combinational)
//  in_rs_a    in   ADDR_W  source A address
//  in_rs_b    in   ADDR_W  source B address
//  in_rd      in   ADDR_W  destination address
//  in_rd_we   in   1       instruction writes in_rd
//  in_ctrl    in   CTRL_W  control field, passed through
//  in_imm     in   DATA_W  immediate, passed through
//  out_valid  out  1       registered outputs valid
//  out_ready  in   1       downstream accepts
//  out_rs_a / out_rs_b / out_rd  out  ADDR_W   registered addresses
//  out_rd_we  out  1       registered write enable
//  out_ctrl   out  CTRL_W  registered control field
//  out_imm    out  DATA_W  registered immediate
//  out_a / out_b  out  DATA_W  operand data for rs_a / rs_b
//  wb_en      in   1       writeback strobe
//  wb_addr    in   ADDR_W  writeback register
//  wb_data    in   DATA_W  writeback data
//  flush      in   1       squash held instruction
// BEHAVIOUR
//  - Reset: all registers = 0, scoreboard = 0, out_valid = 0, all out_* = 0.
//  - r0 reads 0 always; writes to r0 ignored; r0 never pending.
//  - hazard = in_valid & ((pend[in_rs_a] & !byp_a) | (pend[in_rs_b] & !byp_b)).
//    byp_x = wb_en & wb_addr==in_rs_x & in_rs_x!=0 (only with bypass, see CONFIGURATION; else 0).
//  - in_ready = !flush & !hazard & (!out_valid | out_ready). accept = in_valid & in_ready.
//  - Latency 1: on accept, all out_* load next edge, out_valid=1. Operands read from the file, or
//    wb_data when byp_x.
//  - out_valid & !out_ready & !flush: all out_* hold stable.
//  - out_valid & out_ready & !accept: out_valid -> 0.
//  - Scoreboard: accept & in_rd_we & in_rd!=0 sets pend[in_rd]. wb_en clears pend[wb_addr] and writes
//    regs[wb_addr] (wb_addr!=0).
//  - Same edge, same register, set and clear: set wins (new writer outstanding).
//  - wb_en to a non-pending register: data written, pend stays 0.
//  - flush: out_valid -> 0 next edge; if out_valid & out_rd_we & out_rd!=0, pend[out_rd] cleared
//    unless a same-edge set hits it. No accept during flush. wb processed normally.
//  - Reset asserted mid-operation: everything returns to reset values immediately; no partial state.
// CONFIGURATION
//  BYPASS_EN defined: write-through. byp_a/byp_b active; wb cycle resolves hazard, operand = wb_data.
//  BYPASS_EN undefined: byp_x = 0. Instruction waits until the edge after wb (pend clear and file
//  updated), then reads the file. One extra stall cycle per resolved hazard.
// TESTING
//  1. Reset: rst=1 mid-run -> out_valid=0, out_a=out_b=0, in_ready=1 with out_ready=1.
//  2. wb r3=0x12345678, then issue rs_a=3 rs_b=0 -> next cycle out_a=0x12345678, out_b=0.
//  3. Issue rd=5 we=1; next issue rs_a=5 -> in_ready=0. wb r5=0xA5A5A5A5:
//     with BYPASS_EN, accepted that cycle, out_a=0xA5A5A5A5; without, accepted one cycle later.
//  4. out_ready=0 for 3 cycles with out_valid=1 -> all out_* stable, in_ready=0;
//     out_ready=1 -> next instruction loads.
//  5. Held instruction rd=7 we=1, flush=1 -> out_valid=0, pend[7]=0; issue rs_a=7 accepted at once.
//  6. Same edge: accept rd=4 we=1 and wb_en r4 -> pend[4]=1, regs[4]=wb_data.

Source files
------------

// File: rtl/operand_fetch_stage_if.sv
// rtl/operand_fetch_stage_if.sv - bus bundle for the operand fetch stage
// Purpose: groups the upstream issue, downstream pipeline register, writeback
//   and flush signals of operand_fetch_stage.
// Modports:
//   slave  - the stage itself (consumes in_*/wb_*/flush/out_ready, drives in_ready/out_*)
//   master - the surrounding pipeline / testbench
interface operand_fetch_stage_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  parameter int CTRL_W = 4
);
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] in_rs_a;
  logic [ADDR_W-1:0] in_rs_b;
  logic [ADDR_W-1:0] in_rd;
  logic              in_rd_we;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_imm;

  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_rs_a;
  logic [ADDR_W-1:0] out_rs_b;
  logic [ADDR_W-1:0] out_rd;
  logic              out_rd_we;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_imm;
  logic [DATA_W-1:0] out_a;
  logic [DATA_W-1:0] out_b;

  logic              wb_en;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              flush;

  modport slave (
    input  in_valid, in_rs_a, in_rs_b, in_rd, in_rd_we, in_ctrl, in_imm,
    output in_ready,
    output out_valid, out_rs_a, out_rs_b, out_rd, out_rd_we, out_ctrl, out_imm, out_a, out_b,
    input  out_ready,
    input  wb_en, wb_addr, wb_data, flush
  );

  modport master (
    output in_valid, in_rs_a, in_rs_b, in_rd, in_rd_we, in_ctrl, in_imm,
    input  in_ready,
    input  out_valid, out_rs_a, out_rs_b, out_rd, out_rd_we, out_ctrl, out_imm, out_a, out_b,
    output out_ready,
    output wb_en, wb_addr, wb_data, flush
  );
endinterface

// File: rtl/operand_fetch_stage.sv
// rtl/operand_fetch_stage.sv - register file, scoreboard and RAW stall for decode-side operand fetch
// Purpose: holds the 16x32 register file and pending-write scoreboard, reads
//   source operands, stalls on RAW hazards and drives the decode/execute
//   pipeline register.
// Ports:
//   clk - rising-edge clock
//   rst - asynchronous active-high reset
//   bus - operand_fetch_stage_if.slave: issue (in_*), pipeline register (out_*),
//         writeback (wb_*), flush
// Build option: BYPASS_EN - writeback data forwarded to operands in the wb cycle.
module operand_fetch_stage #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  parameter int CTRL_W = 4
) (
  input logic                  clk,
  input logic                  rst,
  operand_fetch_stage_if.slave bus
);
  localparam int NREGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_regs [NREGS];
  logic [NREGS-1:0]  r_pend;

  logic              r_out_valid;
  logic [ADDR_W-1:0] r_out_rs_a;
  logic [ADDR_W-1:0] r_out_rs_b;
  logic [ADDR_W-1:0] r_out_rd;
  logic              r_out_rd_we;
  logic [CTRL_W-1:0] r_out_ctrl;
  logic [DATA_W-1:0] r_out_imm;
  logic [DATA_W-1:0] r_out_a;
  logic [DATA_W-1:0] r_out_b;

  logic              w_byp_a;
  logic              w_byp_b;
  logic              w_hazard;
  logic              w_in_ready;
  logic              w_accept;
  logic [DATA_W-1:0] w_opnd_a;
  logic [DATA_W-1:0] w_opnd_b;
  logic [NREGS-1:0]  w_pend_nxt;

`ifdef BYPASS_EN
  // A writeback landing this cycle satisfies the reader directly.
  assign w_byp_a = bus.wb_en && (bus.wb_addr == bus.in_rs_a) && (bus.in_rs_a != '0);
  assign w_byp_b = bus.wb_en && (bus.wb_addr == bus.in_rs_b) && (bus.in_rs_b != '0);
`else
  // Without forwarding the reader waits for the edge after writeback.
  assign w_byp_a = 1'b0;
  assign w_byp_b = 1'b0;
`endif

  assign w_hazard   = bus.in_valid &&
                      ((r_pend[bus.in_rs_a] && !w_byp_a) || (r_pend[bus.in_rs_b] && !w_byp_b));
  assign w_in_ready = !bus.flush && !w_hazard && (!r_out_valid || bus.out_ready);
  assign w_accept   = bus.in_valid && w_in_ready;

  // r0 is never written, so a plain file read already returns 0 for it.
  assign w_opnd_a = w_byp_a ? bus.wb_data : r_regs[bus.in_rs_a];
  assign w_opnd_b = w_byp_b ? bus.wb_data : r_regs[bus.in_rs_b];

  // Order matters: clears first, then a same-edge set from a new writer wins.
  always_comb begin
    w_pend_nxt = r_pend;
    if (bus.wb_en)
      w_pend_nxt[bus.wb_addr] = 1'b0;
    if (bus.flush && r_out_valid && r_out_rd_we)
      w_pend_nxt[r_out_rd] = 1'b0;
    if (w_accept && bus.in_rd_we)
      w_pend_nxt[bus.in_rd] = 1'b1;
    w_pend_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++)
        r_regs[i] <= '0;
      r_pend <= '0;
    end else begin
      if (bus.wb_en && (bus.wb_addr != '0))
        r_regs[bus.wb_addr] <= bus.wb_data;
      r_pend <= w_pend_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_rs_a  <= '0;
      r_out_rs_b  <= '0;
      r_out_rd    <= '0;
      r_out_rd_we <= 1'b0;
      r_out_ctrl  <= '0;
      r_out_imm   <= '0;
      r_out_a     <= '0;
      r_out_b     <= '0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_rs_a  <= bus.in_rs_a;
      r_out_rs_b  <= bus.in_rs_b;
      r_out_rd    <= bus.in_rd;
      r_out_rd_we <= bus.in_rd_we;
      r_out_ctrl  <= bus.in_ctrl;
      r_out_imm   <= bus.in_imm;
      r_out_a     <= w_opnd_a;
      r_out_b     <= w_opnd_b;
    end else if (bus.flush || bus.out_ready) begin
      // Payload is left in place; only the valid flag drops.
      r_out_valid <= 1'b0;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_rs_a  = r_out_rs_a;
  assign bus.out_rs_b  = r_out_rs_b;
  assign bus.out_rd    = r_out_rd;
  assign bus.out_rd_we = r_out_rd_we;
  assign bus.out_ctrl  = r_out_ctrl;
  assign bus.out_imm   = r_out_imm;
  assign bus.out_a     = r_out_a;
  assign bus.out_b     = r_out_b;
endmodule

// File: tb/tb_operand_fetch_stage.sv
// tb/tb_operand_fetch_stage.sv - self-checking bench for operand_fetch_stage
module tb_operand_fetch_stage;
  localparam int DW = 32;
  localparam int AW = 4;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  operand_fetch_stage_if #(.DATA_W(DW), .ADDR_W(AW), .CTRL_W(CW)) bus ();

  operand_fetch_stage #(.DATA_W(DW), .ADDR_W(AW), .CTRL_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Architectural model: register values, outstanding writers, and the
  // contents of the pipeline register.
  logic [DW-1:0] m_regs [16];
  logic          m_pend [16];
  logic          m_ov;
  logic [AW-1:0] m_rs_a, m_rs_b, m_rd;
  logic          m_rd_we;
  logic [CW-1:0] m_ctrl;
  logic [DW-1:0] m_imm, m_a, m_b;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic m_byp(input logic [AW-1:0] rs);
`ifdef BYPASS_EN
    return bus.wb_en && (bus.wb_addr == rs) && (rs != 0);
`else
    return (rs != rs);
`endif
  endfunction

  function automatic logic m_in_ready();
    logic stall;
    stall = bus.in_valid && ((m_pend[bus.in_rs_a] && !m_byp(bus.in_rs_a)) ||
                             (m_pend[bus.in_rs_b] && !m_byp(bus.in_rs_b)));
    return !bus.flush && !stall && (!m_ov || bus.out_ready);
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 16; i++) begin
      m_regs[i] = '0;
      m_pend[i] = 1'b0;
    end
    m_ov = 0; m_rs_a = 0; m_rs_b = 0; m_rd = 0; m_rd_we = 0;
    m_ctrl = 0; m_imm = 0; m_a = 0; m_b = 0;
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_reset();
      end else begin
        logic          acc;
        logic [DW-1:0] va, vb;
        acc = bus.in_valid && m_in_ready();
        va  = m_byp(bus.in_rs_a) ? bus.wb_data : m_regs[bus.in_rs_a];
        vb  = m_byp(bus.in_rs_b) ? bus.wb_data : m_regs[bus.in_rs_b];
        if (bus.flush && m_ov && m_rd_we && m_rd != 0) m_pend[m_rd] = 1'b0;
        if (bus.wb_en && bus.wb_addr != 0) begin
          m_regs[bus.wb_addr] = bus.wb_data;
          m_pend[bus.wb_addr] = 1'b0;
        end
        if (acc && bus.in_rd_we && bus.in_rd != 0) m_pend[bus.in_rd] = 1'b1;
        if (acc) begin
          m_ov = 1'b1; m_rs_a = bus.in_rs_a; m_rs_b = bus.in_rs_b; m_rd = bus.in_rd;
          m_rd_we = bus.in_rd_we; m_ctrl = bus.in_ctrl; m_imm = bus.in_imm; m_a = va; m_b = vb;
        end else if (bus.flush || (m_ov && bus.out_ready)) begin
          m_ov = 1'b0;
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      chk("in_ready", 64'(bus.in_ready), 64'(m_in_ready()));
      chk("out_valid", 64'(bus.out_valid), 64'(m_ov));
      chk("out_fields", 64'({bus.out_rs_a, bus.out_rs_b, bus.out_rd, bus.out_rd_we, bus.out_ctrl}),
          64'({m_rs_a, m_rs_b, m_rd, m_rd_we, m_ctrl}));
      chk("out_imm", 64'(bus.out_imm), 64'(m_imm));
      chk("out_a", 64'(bus.out_a), 64'(m_a));
      chk("out_b", 64'(bus.out_b), 64'(m_b));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.in_valid = 0; bus.in_rs_a = 0; bus.in_rs_b = 0; bus.in_rd = 0; bus.in_rd_we = 0;
    bus.in_ctrl = 0; bus.in_imm = 0; bus.out_ready = 1; bus.wb_en = 0; bus.wb_addr = 0;
    bus.wb_data = 0; bus.flush = 0;
  endtask

  task automatic issue(input logic [AW-1:0] ra, input logic [AW-1:0] rb, input logic [AW-1:0] rd,
                       input logic we, input logic [CW-1:0] ctrl, input logic [DW-1:0] imm);
    bus.in_valid = 1; bus.in_rs_a = ra; bus.in_rs_b = rb; bus.in_rd = rd;
    bus.in_rd_we = we; bus.in_ctrl = ctrl; bus.in_imm = imm;
  endtask

  task automatic wb(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.wb_en = 1; bus.wb_addr = a; bus.wb_data = d;
  endtask

  initial begin
    idle();
    step(); step();
    chk("reset_out_valid", 64'(bus.out_valid), 64'h0);
    chk("reset_out_a", 64'(bus.out_a), 64'h0);
    rst = 0;
    step();

    // writeback then read: r3 from the file, r0 as zero
    wb(4'd3, 32'h1234_5678);
    step();
    bus.wb_en = 0;
    issue(4'd3, 4'd0, 4'd0, 1'b0, 4'h9, 32'h0000_CAFE);
    step();
    bus.in_valid = 0;
    chk("t2_out_valid", 64'(bus.out_valid), 64'h1);
    chk("t2_out_a", 64'(bus.out_a), 64'h1234_5678);
    chk("t2_out_b", 64'(bus.out_b), 64'h0);
    chk("t2_out_imm", 64'(bus.out_imm), 64'hCAFE);

    // RAW stall on r5 resolved by writeback
    issue(4'd0, 4'd0, 4'd5, 1'b1, 4'h1, 32'h5);
    step();
    issue(4'd5, 4'd0, 4'd0, 1'b0, 4'h2, 32'h6);
    #1;
    chk("t3_stall0", 64'(bus.in_ready), 64'h0);
    step();
    chk("t3_stall1", 64'(bus.in_ready), 64'h0);
    wb(4'd5, 32'hA5A5_A5A5);
    #1;
`ifdef BYPASS_EN
    chk("t3_byp_ready", 64'(bus.in_ready), 64'h1);
    step();
    bus.wb_en = 0; bus.in_valid = 0;
`else
    chk("t3_wb_cycle_ready", 64'(bus.in_ready), 64'h0);
    step();
    bus.wb_en = 0;
    #1;
    chk("t3_after_wb_ready", 64'(bus.in_ready), 64'h1);
    step();
    bus.in_valid = 0;
`endif
    chk("t3_out_a", 64'(bus.out_a), 64'hA5A5_A5A5);
    chk("t3_out_ctrl", 64'(bus.out_ctrl), 64'h2);

    // downstream backpressure holds the register
    issue(4'd0, 4'd0, 4'd6, 1'b0, 4'h3, 32'h1111);
    step();
    bus.out_ready = 0;
    issue(4'd0, 4'd0, 4'd0, 1'b0, 4'h4, 32'h2222);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t4_hold_ready", 64'(bus.in_ready), 64'h0);
      chk("t4_hold_imm", 64'(bus.out_imm), 64'h1111);
      step();
    end
    bus.out_ready = 1;
    #1;
    chk("t4_release_ready", 64'(bus.in_ready), 64'h1);
    step();
    bus.in_valid = 0;
    chk("t4_next_imm", 64'(bus.out_imm), 64'h2222);
    chk("t4_next_ctrl", 64'(bus.out_ctrl), 64'h4);

    // flush squashes the held writer of r7
    issue(4'd0, 4'd0, 4'd7, 1'b1, 4'h5, 32'h7777);
    step();
    bus.in_valid = 0; bus.out_ready = 0; bus.flush = 1;
    step();
    bus.flush = 0; bus.out_ready = 1;
    chk("t5_flushed_valid", 64'(bus.out_valid), 64'h0);
    issue(4'd7, 4'd0, 4'd0, 1'b0, 4'h6, 32'h8888);
    #1;
    chk("t5_r7_ready", 64'(bus.in_ready), 64'h1);
    step();
    bus.in_valid = 0;
    chk("t5_accepted", 64'(bus.out_valid), 64'h1);

    // same-edge set and clear on r4: set wins, data written
    issue(4'd0, 4'd0, 4'd4, 1'b1, 4'h7, 32'h9999);
    wb(4'd4, 32'hDEAD_BEEF);
    step();
    bus.wb_en = 0; bus.in_valid = 0;
    chk("t6_regs4", 64'(dut.r_regs[4]), 64'hDEAD_BEEF);
    issue(4'd4, 4'd0, 4'd0, 1'b0, 4'h8, 32'hAAAA);
    #1;
    chk("t6_r4_pending", 64'(bus.in_ready), 64'h0);

    // asynchronous reset mid-run
    rst = 1;
    #1;
    chk("t1_out_valid", 64'(bus.out_valid), 64'h0);
    chk("t1_out_a", 64'(bus.out_a), 64'h0);
    chk("t1_out_b", 64'(bus.out_b), 64'h0);
    chk("t1_in_ready", 64'(bus.in_ready), 64'h1);
    step();
    rst = 0;
    step();
    bus.in_valid = 0;
    chk("t1_reissue_valid", 64'(bus.out_valid), 64'h1);
    chk("t1_reissue_a", 64'(bus.out_a), 64'h0);
    step(); step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
